// File: rtl/ahbl_pkg.sv
// AHB-Lite encodings, slave FSM states and the registered data-phase record
// shared by the memory slave and its byte-lane decoder.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic        err;
  } dphase_t;

  // Illegal sizes are flagged separately, so only byte/half/word alignment is checked here.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_HALF: return addr[0];
      HSIZE_WORD: return |addr;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_slv_bytelane.sv
// Byte-strobe decode from transfer size and low address bits, little-endian.
// Purely combinational; no flow control.
module ahbl_slv_bytelane
  import ahbl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] strb
);

  always_comb begin
    strb = 4'b0000;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahbl_slv_mem.sv
// AHB-Lite word memory slave; AHBL_SLV_WAIT_EN adds WAIT_CYCLES wait states per OKAY transfer.
// One data-phase cycle plus optional waits; errors take two cycles; stalls via hreadyout.
module ahbl_slv_mem
  import ahbl_pkg::*;
#(
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

  state_e      state;
  dphase_t     dph_q;
  dphase_t     aph_d;
  logic        accept;
  logic        aph_err;
  logic [3:0]  strb;
  logic [IDX_W-1:0] idx;
  logic [31:0] mem [MEM_DEPTH];
  logic        unused_ok;

`ifdef AHBL_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  logic [3:0] wcnt;
`endif

  assign accept  = hsel & htrans[1] & hready;
  assign aph_err = (hsize > HSIZE_WORD) | misaligned(hsize, haddr[1:0]) | (haddr >= MEM_BYTES);
  assign aph_d   = '{addr: haddr, size: hsize, write: hwrite, err: aph_err};
  assign idx     = dph_q.addr[IDX_W+1:2];

  ahbl_slv_bytelane u_bytelane (
    .hsize (dph_q.size),
    .addr  (dph_q.addr[1:0]),
    .strb  (strb)
  );

  // Address phase is only sampled in states that drive hreadyout high.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      dph_q     <= '0;
`ifdef AHBL_SLV_WAIT_EN
      wcnt      <= 4'd0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept) begin
            dph_q <= aph_d;
            if (aph_err) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= HRESP_ERROR;
            end
`ifdef AHBL_SLV_WAIT_EN
            else if (WAIT_CYCLES > 0) begin
              state     <= ST_WAIT;
              wcnt      <= WAIT_LD;
              hreadyout <= 1'b0;
              hresp     <= HRESP_OKAY;
            end
`endif
            else begin
              state     <= ST_DATA;
              hreadyout <= 1'b1;
              hresp     <= HRESP_OKAY;
            end
          end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
          end
        end
`ifdef AHBL_SLV_WAIT_EN
        ST_WAIT: begin
          if (wcnt == 4'd0) begin
            state     <= ST_DATA;
            hreadyout <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
`endif
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Commit lands on the DATA edge, so a pipelined read in the next cycle sees it.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_DATA && dph_q.write && !dph_q.err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (state == ST_DATA && !dph_q.write && !dph_q.err) hrdata = mem[idx];
  end

  assign unused_ok = ^{hburst, hprot, htrans[0], dph_q.addr[31:IDX_W+2], (WAIT_CYCLES != 0)};

endmodule

// File: tb/tb_ahbl_slv_mem.sv
// Randomised and directed bench for ahbl_slv_mem against a byte-addressed reference memory.
module tb_ahbl_slv_mem;

  localparam int MEM_DEPTH   = 16;
  localparam int WAIT_CYCLES = 2;
  localparam int MAXOPS      = 64;
`ifdef AHBL_SLV_WAIT_EN
  localparam int EXP_WAIT = WAIT_CYCLES;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        hclk, hreset, hsel, hwrite, hready, hready_mask, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] mem_m [MEM_DEPTH];
  logic        op_w [MAXOPS];
  logic [31:0] op_a [MAXOPS];
  logic [2:0]  op_s [MAXOPS];
  logic [31:0] op_d [MAXOPS];
  logic        ex_err [MAXOPS];
  logic [31:0] ex_rd [MAXOPS];
  int          ob_wait [MAXOPS];
  logic        ob_resp [MAXOPS];
  logic        ob_sany [MAXOPS];
  logic [31:0] ob_rdata [MAXOPS];

  assign hready = hreadyout & hready_mask;

  ahbl_slv_mem #(.MEM_DEPTH(MEM_DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, required to finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: byte-addressed memory; a transfer errors on bad size, alignment or range.
  function automatic void model_op(input logic w, input logic [31:0] a, input logic [2:0] s,
                                   input logic [31:0] d, output logic err, output logic [31:0] rd);
    int nb;
    nb  = 1 << s;
    err = (s > 3'd2) || (a % nb != 0) || (a >= MEM_DEPTH * 4);
    rd  = '0;
    if (!err) begin
      if (w) begin
        for (int b = int'(a); b < int'(a) + nb; b++)
          mem_m[b / 4][(b % 4) * 8 +: 8] = d[(b % 4) * 8 +: 8];
      end else begin
        rd = mem_m[a / 4];
      end
    end
  endfunction

  function automatic void model_clear();
    foreach (mem_m[i]) mem_m[i] = '0;
  endfunction

  task automatic set_op(input int i, input logic w, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d);
    op_w[i] = w; op_a[i] = a; op_s[i] = s; op_d[i] = d;
  endtask

  task automatic plan(input int n);
    for (int i = 0; i < n; i++) model_op(op_w[i], op_a[i], op_s[i], op_d[i], ex_err[i], ex_rd[i]);
  endtask

  task automatic drive_addr(input int k, input int n);
    hburst = 3'($urandom_range(0, 7));
    hprot  = 4'($urandom_range(0, 15));
    if (k < n) begin
      hsel = 1'b1; htrans = 2'($urandom_range(2, 3));
      haddr = op_a[k]; hsize = op_s[k]; hwrite = op_w[k];
    end else begin
      hsel = 1'b0; htrans = 2'd0; haddr = '0; hsize = 3'd0; hwrite = 1'b0;
    end
  endtask

  // Issues ops 0..n-1 as a fully pipelined stream, honouring hreadyout, and records observations.
  task automatic run_ops(input int n);
    int   acc, dp, cyc, guard;
    logic took;
    acc = 0; dp = -1; cyc = 0; guard = 0;
    @(negedge hclk);
    drive_addr(0, n);
    took = hready;
    while (acc < n || dp >= 0) begin
      @(negedge hclk);
      if (took && acc < n) begin
        dp = acc; acc++; cyc = 0; ob_sany[dp] = 1'b0;
        hwdata = op_d[dp];
        drive_addr(acc, n);
      end
      if (dp >= 0) begin
        if (hreadyout) begin
          ob_wait[dp] = cyc; ob_resp[dp] = hresp; ob_rdata[dp] = hrdata; dp = -1;
        end else begin
          cyc++; ob_sany[dp] = ob_sany[dp] | hresp;
        end
      end
      took = hready;
      guard++;
      if (guard > 400) begin
        ntests++; nfail++;
        $display("FAIL run_ops stall: op %0d still pending after %0d cycles, required completion", dp, guard);
        drive_addr(n, n);
        return;
      end
    end
  endtask

  task automatic test_reset();
    hreset = 1'b1; hready_mask = 1'b1; hwdata = '0;
    drive_addr(0, 0);
    repeat (3) @(negedge hclk);
    ntests++; if (hreadyout !== 1'b1) begin nfail++; $display("FAIL reset hreadyout: got %b, required 1", hreadyout); end
    ntests++; if (hresp !== 1'b0) begin nfail++; $display("FAIL reset hresp: got %b, required 0", hresp); end
    ntests++; if (hrdata !== 32'h0) begin nfail++; $display("FAIL reset hrdata: got %h, required 0", hrdata); end
    hreset = 1'b0;
    model_clear();
    set_op(0, 1'b0, 32'h00, 3'd2, '0);
    set_op(1, 1'b0, 32'h3C, 3'd2, '0);
    plan(2); run_ops(2);
    for (int i = 0; i < 2; i++) begin
      ntests++; if (ob_rdata[i] !== 32'h0) begin nfail++; $display("FAIL reset mem[%h]: got %h, required 0", op_a[i], ob_rdata[i]); end
    end
  endtask

  task automatic test_word_rw();
    set_op(0, 1'b1, 32'h08, 3'd2, 32'hDEADBEEF); plan(1); run_ops(1);
    ntests++; if (ob_wait[0] !== EXP_WAIT) begin nfail++; $display("FAIL word_wr waits: got %0d, required %0d", ob_wait[0], EXP_WAIT); end
    ntests++; if (ob_resp[0] !== 1'b0) begin nfail++; $display("FAIL word_wr hresp: got %b, required 0", ob_resp[0]); end
    set_op(0, 1'b0, 32'h08, 3'd2, 32'h0); plan(1); run_ops(1);
    ntests++; if (ob_rdata[0] !== 32'hDEADBEEF) begin nfail++; $display("FAIL word_rd data: got %h, required deadbeef", ob_rdata[0]); end
    ntests++; if (ob_wait[0] !== EXP_WAIT) begin nfail++; $display("FAIL word_rd waits: got %0d, required %0d", ob_wait[0], EXP_WAIT); end
    ntests++; if (ob_resp[0] !== 1'b0 || ob_sany[0] !== 1'b0) begin nfail++; $display("FAIL word_rd hresp: got %b/%b, required 0/0", ob_resp[0], ob_sany[0]); end
  endtask

  task automatic test_byte_lanes();
    set_op(0, 1'b1, 32'h0C, 3'd2, 32'h11223344);
    set_op(1, 1'b1, 32'h0D, 3'd0, 32'h0000AA00);
    set_op(2, 1'b0, 32'h0C, 3'd2, 32'h0);
    set_op(3, 1'b1, 32'h0E, 3'd1, 32'hBEEF0000);
    set_op(4, 1'b0, 32'h0C, 3'd2, 32'h0);
    plan(5); run_ops(5);
    ntests++; if (ob_rdata[2] !== 32'h1122AA44) begin nfail++; $display("FAIL byte_wr data: got %h, required 1122aa44", ob_rdata[2]); end
    ntests++; if (ob_rdata[4] !== 32'hBEEFAA44) begin nfail++; $display("FAIL half_wr data: got %h, required beefaa44", ob_rdata[4]); end
    ntests++; if (ob_resp[1] !== 1'b0 || ob_resp[3] !== 1'b0) begin nfail++; $display("FAIL lanes hresp: got %b/%b, required 0/0", ob_resp[1], ob_resp[3]); end
  endtask

  task automatic test_range_error();
    set_op(0, 1'b0, 32'h40, 3'd2, 32'h0);
    set_op(1, 1'b1, 32'h40, 3'd2, 32'hFFFFFFFF);
    set_op(2, 1'b0, 32'h00, 3'd3, 32'h0);
    set_op(3, 1'b0, 32'h3C, 3'd2, 32'h0);
    plan(4); run_ops(4);
    ntests++; if (ob_wait[0] !== 1) begin nfail++; $display("FAIL range_err waits: got %0d, required 1", ob_wait[0]); end
    ntests++; if (ob_sany[0] !== 1'b1) begin nfail++; $display("FAIL range_err err1 hresp: got %b, required 1", ob_sany[0]); end
    ntests++; if (ob_resp[0] !== 1'b1) begin nfail++; $display("FAIL range_err err2 hresp: got %b, required 1", ob_resp[0]); end
    ntests++; if (ob_rdata[0] !== 32'h0) begin nfail++; $display("FAIL range_err hrdata: got %h, required 0", ob_rdata[0]); end
    ntests++; if (ob_resp[2] !== 1'b1 || ob_wait[2] !== 1) begin nfail++; $display("FAIL size_err: got resp %b waits %0d, required 1 and 1", ob_resp[2], ob_wait[2]); end
    ntests++; if (ob_rdata[3] !== ex_rd[3] || ob_resp[3] !== 1'b0) begin nfail++; $display("FAIL range_edge read: got %h/%b, required %h/0", ob_rdata[3], ob_resp[3], ex_rd[3]); end
  endtask

  task automatic test_misaligned();
    set_op(0, 1'b1, 32'h00, 3'd2, 32'h55667788);
    set_op(1, 1'b1, 32'h01, 3'd1, 32'hFFFFFFFF);
    set_op(2, 1'b1, 32'h02, 3'd2, 32'hFFFFFFFF);
    set_op(3, 1'b0, 32'h00, 3'd2, 32'h0);
    plan(4); run_ops(4);
    ntests++; if (ob_resp[1] !== 1'b1 || ob_sany[1] !== 1'b1 || ob_wait[1] !== 1) begin nfail++; $display("FAIL misalign_half: got resp %b/%b waits %0d, required 1/1 and 1", ob_sany[1], ob_resp[1], ob_wait[1]); end
    ntests++; if (ob_resp[2] !== 1'b1) begin nfail++; $display("FAIL misalign_word hresp: got %b, required 1", ob_resp[2]); end
    ntests++; if (ob_rdata[3] !== 32'h55667788) begin nfail++; $display("FAIL misalign readback: got %h, required 55667788", ob_rdata[3]); end
  endtask

  task automatic test_back_to_back();
    int stalls;
    set_op(0, 1'b1, 32'h04, 3'd2, 32'h13579BDF);
    set_op(1, 1'b0, 32'h04, 3'd2, 32'h0);
    plan(2); run_ops(2);
    stalls = ob_wait[0] + ob_wait[1];
    ntests++; if (stalls !== 2 * EXP_WAIT) begin nfail++; $display("FAIL b2b stall cycles: got %0d, required %0d", stalls, 2 * EXP_WAIT); end
    ntests++; if (ob_rdata[1] !== 32'h13579BDF) begin nfail++; $display("FAIL b2b read: got %h, required 13579bdf", ob_rdata[1]); end
    ntests++; if (ob_resp[0] !== 1'b0 || ob_resp[1] !== 1'b0) begin nfail++; $display("FAIL b2b hresp: got %b/%b, required 0/0", ob_resp[0], ob_resp[1]); end
  endtask

  task automatic test_not_accepted();
    hwdata = 32'hFFFFFFFF; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      hsel = (k != 0); htrans = (k == 1) ? 2'd1 : 2'd2; hready_mask = (k != 2);
      @(negedge hclk);
      ntests++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin nfail++; $display("FAIL no_accept case %0d: got rdy %b resp %b, required 1/0", k, hreadyout, hresp); end
    end
    drive_addr(0, 0); hready_mask = 1'b1;
    set_op(0, 1'b0, 32'h10, 3'd2, 32'h0); plan(1); run_ops(1);
    ntests++; if (ob_rdata[0] !== ex_rd[0]) begin nfail++; $display("FAIL no_accept readback: got %h, required %h", ob_rdata[0], ex_rd[0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  s;
      logic [31:0] a;
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(64, 255)) : 32'($urandom_range(0, 63));
      if (s <= 3'd2 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
      set_op(i, 1'($urandom_range(0, 1)), a, s, $urandom());
    end
    plan(40); run_ops(40);
    for (int i = 0; i < 40; i++) begin
      ntests++; if (ob_resp[i] !== ex_err[i]) begin nfail++; $display("FAIL rnd[%0d] hresp: got %b, required %b", i, ob_resp[i], ex_err[i]); end
      ntests++; if (ob_wait[i] !== (ex_err[i] ? 1 : EXP_WAIT)) begin nfail++; $display("FAIL rnd[%0d] waits: got %0d, required %0d", i, ob_wait[i], ex_err[i] ? 1 : EXP_WAIT); end
      ntests++; if (ob_sany[i] !== ex_err[i]) begin nfail++; $display("FAIL rnd[%0d] stall hresp: got %b, required %b", i, ob_sany[i], ex_err[i]); end
      ntests++; if (ob_rdata[i] !== ex_rd[i]) begin nfail++; $display("FAIL rnd[%0d] hrdata @%h: got %h, required %h", i, op_a[i], ob_rdata[i], ex_rd[i]); end
    end
  endtask

  task automatic test_reset_inflight();
    set_op(0, 1'b1, 32'h08, 3'd2, 32'hA5A5A5A5); plan(1); run_ops(1);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h00; hsize = 3'd2; hwrite = 1'b1;
    @(negedge hclk);
    drive_addr(0, 0); hwdata = 32'hCAFEF00D; hreset = 1'b1;
    ntests++; if (hreadyout !== (EXP_WAIT == 0)) begin nfail++; $display("FAIL inflight stall: got rdy %b, required %b", hreadyout, EXP_WAIT == 0); end
    @(negedge hclk);
    hreset = 1'b0;
    ntests++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin nfail++; $display("FAIL inflight reset: got rdy %b resp %b, required 1/0", hreadyout, hresp); end
    model_clear();
    set_op(0, 1'b0, 32'h00, 3'd2, 32'h0);
    set_op(1, 1'b0, 32'h08, 3'd2, 32'h0);
    plan(2); run_ops(2);
    ntests++; if (ob_rdata[0] !== 32'h0) begin nfail++; $display("FAIL inflight write dropped: got %h, required 0", ob_rdata[0]); end
    ntests++; if (ob_rdata[1] !== 32'h0) begin nfail++; $display("FAIL inflight mem cleared: got %h, required 0", ob_rdata[1]); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_range_error();
    test_misaligned();
    test_back_to_back();
    test_not_accepted();
    test_random();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
